sfu_ctrl: RTL

SFU_CTRL -- requirements
Module: sfu_ctrl

---
 rtl/sfu_ctrl_pkg.sv | 23 ++
 rtl/sfu_ctrl_mod_counter.sv | 26 ++
 rtl/sfu_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/sfu_ctrl_pkg.sv
// Shared types and defaults for the SFU accumulate/readout controller.
package sfu_ctrl_pkg;

    localparam int INPUT_CH = 16;
    localparam int PASS_BW  = 4;

    // Counter width that still works for a degenerate single-channel bank.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CNT_W = cnt_w(INPUT_CH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ACC,
        S_PTR_RST,
        S_OUT,
        S_DONE
    } state_t;

endpackage

// File: rtl/sfu_ctrl_mod_counter.sv
// Modulo-N event counter; wrap flags the increment that returns it to zero.
module mod_counter
    import sfu_ctrl_pkg::*;
#(
    parameter int N = INPUT_CH,
    localparam int W = cnt_w(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         wrap
);

    assign wrap = inc && (count == W'(N - 1));

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/sfu_ctrl.sv
// Sequences SFU clear, multi-pass psum accumulation and ReLU readout for one job.
module sfu_ctrl
    import sfu_ctrl_pkg::*;
#(
    parameter int input_ch = INPUT_CH,
    parameter int pass_bw  = PASS_BW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [pass_bw-1:0] num_pass,
    input  logic               src_valid,
    output logic               src_rd,
    output logic               sfu_valid,
    output logic               sfu_enable,
    output logic               sfu_clr,
    output logic               sfu_reset_ptr,
    output logic               sfu_out_en,
    input  logic               out_ready,
    output logic               out_valid,
    output logic               busy,
    output logic               done
);

    localparam int CW = cnt_w(input_ch);

    state_t             state, next_state;
    logic [pass_bw-1:0] pass_cnt;
    logic [pass_bw-1:0] pass_last;
    logic [CW-1:0]      ch_cnt, out_cnt;
    logic               ch_wrap, out_wrap;
    logic               in_clear;
    logic               out_en_p1;

    assign in_clear = (state == S_CLEAR);

    mod_counter #(.N(input_ch)) u_ch_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (src_rd),
        .clr   (in_clear),
        .count (ch_cnt),
        .wrap  (ch_wrap)
    );

    mod_counter #(.N(input_ch)) u_out_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (sfu_out_en),
        .clr   (in_clear),
        .count (out_cnt),
        .wrap  (out_wrap)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Job configuration and pass bookkeeping; a pass count of 0 runs one pass.
    always_ff @(posedge clk) begin
        if (reset) begin
            pass_last <= '0;
            pass_cnt  <= '0;
            out_en_p1 <= 1'b0;
        end else begin
            if (state == S_IDLE && start) begin
                pass_last <= (num_pass == '0) ? '0 : num_pass - 1'b1;
            end
            if (in_clear) begin
                pass_cnt <= '0;
            end else if (state == S_PTR_RST) begin
                pass_cnt <= pass_cnt + 1'b1;
            end
            out_en_p1 <= sfu_out_en;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:    if (start) next_state = S_CLEAR;
            S_CLEAR:   next_state = S_ACC;
            S_ACC:     if (ch_wrap) next_state = S_PTR_RST;
            S_PTR_RST: next_state = (pass_cnt == pass_last) ? S_OUT : S_ACC;
            S_OUT:     if (out_wrap) next_state = S_DONE;
            S_DONE:    next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    // Every output is forced low while reset is held, even mid-job.
    always_comb begin
        src_rd        = 1'b0;
        sfu_clr       = 1'b0;
        sfu_reset_ptr = 1'b0;
        sfu_out_en    = 1'b0;
        done          = 1'b0;
        busy          = 1'b0;
        if (!reset) begin
            busy = (state != S_IDLE);
            case (state)
                S_CLEAR:   sfu_clr       = 1'b1;
                S_ACC:     src_rd        = src_valid;
                S_PTR_RST: sfu_reset_ptr = 1'b1;
                S_OUT:     sfu_out_en    = out_ready;
                S_DONE:    done          = 1'b1;
                default:   ;
            endcase
        end
        sfu_valid  = src_rd;
        sfu_enable = src_rd;
        out_valid  = out_en_p1 & ~reset;
    end

endmodule
